jogador_automatico: RTL
=======================

# jogador_automatico

Hardware auto-player for the memory game core (`circuito_exp5`). It drives the game from the player side: it pulses `jogar`, then presses `botoes` for rounds 0..NUM_ROUNDS-1, replaying jogadas 0..r of a fixed 16-entry sequence in round r. It monitors `ganhou`/`perdeu` and reports the outcome. It sits beside the game core on the board top and replaces the manual bench stimulus, which makes self-playing demos and regression runs possible.

## Interface

- `START_CYCLES`, 5: cycles `jogar` is held high.
- `START_WAIT`, 10: idle cycles after `jogar` falls, before the first press.
- `PRESS_CYCLES`, 10: cycles each button is held.
- `GAP_CYCLES`, 10: cycles with `botoes`=0 after each press.
- `NUM_ROUNDS`, 16: rounds played, 1..16.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `iniciar` in 1: start request, level-sampled.
- `injeta_erro` in 1: when 1, a deliberate wrong press is made.
- `erro_rodada` in 4: round in which the wrong press is made.
- `ganhou` in 1: from game core.
- `perdeu` in 1: from game core.
- `jogar` out 1: to game core.
- `botoes` out 4: to game core, one-hot or 0.
- `ativo` out 1: high in any state other than OCIOSO or FIM_*.
- `fim` out 1: high in FIM_* states.
- `ganhou_visto` out 1: outcome flag.
- `perdeu_visto` out 1: outcome flag.
- `db_rodada` out 4: current round.
- `db_jogada` out 4: current jogada index within the round.
- `db_estado` out 4: state code.

## Operation

- Sequence ROM, indices 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- All outputs are Moore (registered state plus counters).
- State codes:
  - OCIOSO=0
  - PULSO_JOGAR=1
  - ESPERA_INICIO=2
  - PRESSIONA=3
  - SOLTA=4
  - FIM_OK=A
  - FIM_ERRO=E
  - FIM_SEM_RESPOSTA=F
- OCIOSO:
  - `iniciar`=1 → PULSO_JOGAR.
  - On entry: latch `injeta_erro`/`erro_rodada`; clear rodada, jogada, timer, both flags.
- PULSO_JOGAR: `jogar`=1 for START_CYCLES cycles → ESPERA_INICIO.
- ESPERA_INICIO: all outputs 0 for START_WAIT cycles → PRESSIONA.
- PRESSIONA:
  - `botoes`=ROM[jogada] for PRESS_CYCLES cycles → SOLTA.
  - Exception: if the error is latched and rodada==erro_rodada and jogada==rodada, drive ROM[jogada] rotated left by one, i.e. {b[2:0],b[3]}.
- SOLTA: `botoes`=0 for GAP_CYCLES cycles, then:
  - jogada<rodada → jogada+1, go to PRESSIONA.
  - else if rodada<NUM_ROUNDS-1 → rodada+1, jogada=0, go to PRESSIONA.
  - else → FIM_SEM_RESPOSTA.
- Monitoring, in ESPERA_INICIO, PRESSIONA and SOLTA:
  - `perdeu`=1 → FIM_ERRO, `perdeu_visto`=1.
  - otherwise `ganhou`=1 → FIM_OK, `ganhou_visto`=1.
  - `perdeu` has priority when both are high.
  - `botoes` goes to 0 on the next edge.
- FIM_*:
  - Hold flags, `fim`=1, `botoes`=0, `jogar`=0.
  - `iniciar`=1 → PULSO_JOGAR; flags cleared and error config re-latched.
- `iniciar` is ignored in PULSO_JOGAR, ESPERA_INICIO, PRESSIONA and SOLTA.
- Timer is 8 bits, so all cycle parameters are limited to 1..255.
- Timer reloads to 0 on every state change. A state lasts exactly its parameter in cycles.

## Timing

- Reset (`reset`=0 at a rising edge), from any state:
  - next state OCIOSO.
  - outputs: `jogar`=0, `botoes`=0000, `ativo`=0, `fim`=0, `ganhou_visto`=0, `perdeu_visto`=0, `db_rodada`=0, `db_jogada`=0, `db_estado`=0.
  - latched error config cleared.
  - mid-press reset releases `botoes` on that edge.
- Start: `iniciar` is sampled at edge E. `jogar` is high during [E, E+START_CYCLES).
- First press starts at E+START_CYCLES+START_WAIT, which is E+15 with defaults.
- Press k (global, 0-based) starts at E+15+20k with defaults.
- Full run with no game response: 136 presses, FIM_SEM_RESPOSTA entered at E+15+2720=E+2735.
- Response latency: `ganhou`/`perdeu` high in cycle sampled at edge T → `fim`=1 and flag set from T.

## Test plan

- Reset mid-PRESSIONA (round 3, jogada 2): `reset`=0 for one edge → `botoes`=0, `db_estado`=0, `db_rodada`=0, `ativo`=0. A later `iniciar` restarts from round 0.
- Default params, `ganhou`/`perdeu` tied 0, `iniciar` pulse at E:
  - `jogar` high 5 cycles.
  - `botoes`=0001 during [E+15, E+25), then 0 until E+35.
  - 0001 during [E+35, E+45), 0010 during [E+55, E+65).
  - `fim`=1 with `db_estado`=F at E+2735, both flags 0.
- `injeta_erro`=1, `erro_rodada`=0: first press is 0010. Model game asserts `perdeu` at E+20 → `fim`=1, `perdeu_visto`=1, `db_estado`=E, `botoes`=0 from E+20.
- `injeta_erro`=1, `erro_rodada`=2: round 2 presses are 0001, 0010, 1000 (rotated 0100). Rounds 0–1 are unchanged.
- `ganhou` and `perdeu` asserted in the same cycle during SOLTA → FIM_ERRO, `perdeu_visto`=1, `ganhou_visto`=0.
- In FIM_OK, `iniciar`=1 → flags clear, `jogar` high for 5 cycles, round 0 replays. `iniciar` pulsed during PRESSIONA has no effect.

Source files
------------

// File: rtl/jogador_automatico_if.sv
// Player-side bundle between the auto-player and the memory game core.
interface jogador_automatico_if;
    logic       iniciar;
    logic       injeta_erro;
    logic [3:0] erro_rodada;
    logic       ganhou;
    logic       perdeu;
    logic       jogar;
    logic [3:0] botoes;
    logic       ativo;
    logic       fim;
    logic       ganhou_visto;
    logic       perdeu_visto;
    logic [3:0] db_rodada;
    logic [3:0] db_jogada;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, injeta_erro, erro_rodada, ganhou, perdeu,
        output jogar, botoes, ativo, fim, ganhou_visto, perdeu_visto,
        output db_rodada, db_jogada, db_estado
    );

    modport slave (
        output iniciar, injeta_erro, erro_rodada, ganhou, perdeu,
        input  jogar, botoes, ativo, fim, ganhou_visto, perdeu_visto,
        input  db_rodada, db_jogada, db_estado
    );
endinterface

// File: rtl/jogador_automatico.sv
// Auto-player for the memory game: pulses jogar, replays the sequence
// round by round and records whether the game reported win or loss.
module jogador_automatico #(
    parameter int START_CYCLES = 5,
    parameter int START_WAIT   = 10,
    parameter int PRESS_CYCLES = 10,
    parameter int GAP_CYCLES   = 10,
    parameter int NUM_ROUNDS   = 16
) (
    input  logic           clock,
    input  logic           reset,
    jogador_automatico_if.master bus
);

    typedef enum logic [3:0] {
        OCIOSO           = 4'h0,
        PULSO_JOGAR      = 4'h1,
        ESPERA_INICIO    = 4'h2,
        PRESSIONA        = 4'h3,
        SOLTA            = 4'h4,
        FIM_OK           = 4'hA,
        FIM_ERRO         = 4'hE,
        FIM_SEM_RESPOSTA = 4'hF
    } estado_t;

    localparam logic [7:0] START_LAST = 8'(START_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(START_WAIT - 1);
    localparam logic [7:0] PRESS_LAST = 8'(PRESS_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    estado_t    estado_q, estado_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] rodada_q, rodada_d;
    logic [3:0] jogada_q, jogada_d;
    logic       ganhou_q, ganhou_d;
    logic       perdeu_q, perdeu_d;
    logic       err_en_q, err_en_d;
    logic [3:0] err_rod_q, err_rod_d;
    logic       monitora;
    logic [3:0] tecla;

    function automatic logic [3:0] rom(input logic [3:0] idx);
        logic [3:0] v;
        case (idx)
            4'd0:    v = 4'b0001;
            4'd1:    v = 4'b0010;
            4'd2:    v = 4'b0100;
            4'd3:    v = 4'b1000;
            4'd4:    v = 4'b0100;
            4'd5:    v = 4'b0010;
            4'd6:    v = 4'b0001;
            4'd7:    v = 4'b0001;
            4'd8:    v = 4'b0010;
            4'd9:    v = 4'b0010;
            4'd10:   v = 4'b0100;
            4'd11:   v = 4'b0100;
            4'd12:   v = 4'b1000;
            4'd13:   v = 4'b1000;
            4'd14:   v = 4'b0001;
            default: v = 4'b0100;
        endcase
        return v;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            timer_q   <= '0;
            rodada_q  <= '0;
            jogada_q  <= '0;
            ganhou_q  <= 1'b0;
            perdeu_q  <= 1'b0;
            err_en_q  <= 1'b0;
            err_rod_q <= '0;
        end else begin
            estado_q  <= estado_d;
            timer_q   <= timer_d;
            rodada_q  <= rodada_d;
            jogada_q  <= jogada_d;
            ganhou_q  <= ganhou_d;
            perdeu_q  <= perdeu_d;
            err_en_q  <= err_en_d;
            err_rod_q <= err_rod_d;
        end
    end

    assign monitora = (estado_q == ESPERA_INICIO) ||
                      (estado_q == PRESSIONA) ||
                      (estado_q == SOLTA);

    always_comb begin
        estado_d  = estado_q;
        timer_d   = timer_q + 8'd1;
        rodada_d  = rodada_q;
        jogada_d  = jogada_q;
        ganhou_d  = ganhou_q;
        perdeu_d  = perdeu_q;
        err_en_d  = err_en_q;
        err_rod_d = err_rod_q;
        unique case (estado_q)
            OCIOSO, FIM_OK, FIM_ERRO, FIM_SEM_RESPOSTA: begin
                timer_d = '0;
                if (bus.iniciar) begin
                    estado_d  = PULSO_JOGAR;
                    rodada_d  = '0;
                    jogada_d  = '0;
                    ganhou_d  = 1'b0;
                    perdeu_d  = 1'b0;
                    err_en_d  = bus.injeta_erro;
                    err_rod_d = bus.erro_rodada;
                end
            end
            PULSO_JOGAR: begin
                if (timer_q == START_LAST) begin
                    estado_d = ESPERA_INICIO;
                    timer_d  = '0;
                end
            end
            ESPERA_INICIO: begin
                if (timer_q == WAIT_LAST) begin
                    estado_d = PRESSIONA;
                    timer_d  = '0;
                end
            end
            PRESSIONA: begin
                if (timer_q == PRESS_LAST) begin
                    estado_d = SOLTA;
                    timer_d  = '0;
                end
            end
            SOLTA: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (jogada_q < rodada_q) begin
                        jogada_d = jogada_q + 4'd1;
                        estado_d = PRESSIONA;
                    end else if (rodada_q < LAST_ROUND) begin
                        rodada_d = rodada_q + 4'd1;
                        jogada_d = '0;
                        estado_d = PRESSIONA;
                    end else begin
                        estado_d = FIM_SEM_RESPOSTA;
                    end
                end
            end
            default: begin
                estado_d = OCIOSO;
                timer_d  = '0;
            end
        endcase
        // A game response overrides any sequencing decision this cycle.
        if (monitora && bus.perdeu) begin
            estado_d = FIM_ERRO;
            perdeu_d = 1'b1;
            timer_d  = '0;
        end else if (monitora && bus.ganhou) begin
            estado_d = FIM_OK;
            ganhou_d = 1'b1;
            timer_d  = '0;
        end
    end

    always_comb begin
        tecla = rom(jogada_q);
        if (err_en_q && (rodada_q == err_rod_q) && (jogada_q == rodada_q))
            tecla = {tecla[2:0], tecla[3]};
    end

    always_comb begin
        bus.jogar        = 1'b0;
        bus.botoes       = 4'b0000;
        bus.ativo        = 1'b0;
        bus.fim          = 1'b0;
        bus.ganhou_visto = ganhou_q;
        bus.perdeu_visto = perdeu_q;
        bus.db_rodada    = rodada_q;
        bus.db_jogada    = jogada_q;
        bus.db_estado    = estado_q;
        unique case (estado_q)
            PULSO_JOGAR: begin
                bus.jogar = 1'b1;
                bus.ativo = 1'b1;
            end
            ESPERA_INICIO, SOLTA: begin
                bus.ativo = 1'b1;
            end
            PRESSIONA: begin
                bus.ativo  = 1'b1;
                bus.botoes = tecla;
            end
            FIM_OK, FIM_ERRO, FIM_SEM_RESPOSTA: begin
                bus.fim = 1'b1;
            end
            default: begin
                bus.jogar = 1'b0;
            end
        endcase
    end

endmodule
